systolic_array_drain: RTL and testbench
=======================================

SYSTOLIC_ARRAY_DRAIN -- requirements
Module: systolic_array_drain

Interface
REQ-001 Parameter NUM_COL, default 4, is the number of array columns drained (range 2..16).
REQ-002 Parameter BW_ACCU, default 32, is the bit length of each accumulated column result.
REQ-003 Parameter FIFO_DEPTH, default 8, is the row-FIFO depth in rows (power of 2, >= 2*NUM_COL).
REQ-004 clk  input  1  is the single clock; all state is updated on its rising edge.
REQ-005 reset_n  input  1  is the asynchronous, active-low reset.
REQ-006 drain_enable  input  1  means bottom-row outputs carry partial sums; when low, they carry weights and are ignored.
REQ-007 col_valid_in  input  NUM_COL  is the per-column valid, skewed so that column c of row r arrives c cycles after column 0 of row r.
REQ-008 col_data_in  input  NUM_COL*BW_ACCU  is the signed bottom-PE output, with column c at bits [c*BW_ACCU +: BW_ACCU].
REQ-009 out_valid / out_ready  output / input  1 / 1  form the row-output handshake.
REQ-010 out_data  output  NUM_COL*BW_ACCU  is the deskewed row, with column c at the same slice position as col_data_in.
REQ-011 array_stall  output  1  requests the array controller to hold PE_mac_enable low.
REQ-012 skew_err, overflow_err  output  1 each  are sticky error flags.
REQ-013 clear_err  input  1  is a synchronous clear of both error flags.
REQ-014 rows_drained  output  16  counts rows pushed into the FIFO.

Function
REQ-015 Column c data and valid shall pass through NUM_COL-1-c pipeline registers, so column NUM_COL-1 is used undelayed.
REQ-016 Valids shall be gated with drain_enable at the delay-line input, so entries captured while drain_enable=0 are invalid.
REQ-017 An aligned row shall be pushed at an edge where all NUM_COL aligned valids are 1 and the FIFO is not full (or a pop occurs on that same edge).
REQ-018 If the aligned valid vector is neither all-0 nor all-1, the row shall be dropped and skew_err set on that edge.
REQ-019 A push while the FIFO is full with no simultaneous pop shall drop the row, set overflow_err, and leave FIFO contents unchanged.
REQ-020 A pop shall occur on an edge with out_valid=1 and out_ready=1; out_data shall be stable while out_valid=1 and out_ready=0.
REQ-021 out_valid shall be driven from registered FIFO state: a push into an empty FIFO gives out_valid=1 in the next cycle.
REQ-022 End-to-end latency shall be NUM_COL cycles from column 0 sampling to out_valid, when the FIFO is empty.
REQ-023 A simultaneous push and pop shall keep the count constant and be legal at full.
REQ-024 array_stall shall be 1 when FIFO count >= FIFO_DEPTH-NUM_COL, as a combinational function of registered count.
REQ-025 rows_drained shall increment by 1 per successful push and wrap from 16'hFFFF to 0.
REQ-026 If clear_err and an error event occur on the same edge, the flag shall be set (set wins).
REQ-027 Data shall pass unmodified (no sign extension or truncation); out_data bits shall be X-free after reset.

Reset
REQ-028 When reset_n=0, the following shall be cleared immediately and asynchronously: delay lines (valid and data), FIFO pointers and count, out_valid, array_stall, skew_err, overflow_err, rows_drained, and out_data.
REQ-029 Reset mid-drain shall discard all in-flight and buffered rows; no row shall be emitted after release until new valids arrive.

Structure
REQ-030 Package systolic_pkg shall hold the default BW_ACCU, accu_t (signed [BW_ACCU-1:0]), and the default NUM_COL, shared with the array top.
REQ-031 The row FIFO shall be sub-module drain_fifo (synchronous FIFO with push, pop, full, empty, and count outputs).
REQ-032 Deskew registers, error logic, and the counter shall reside in systolic_array_drain.

Verification (NUM_COL=4, FIFO_DEPTH=8, BW_ACCU=32)
REQ-033 Single row: col c valid at cycle 10+c with data 100+c, out_ready=1 -> out_valid high in cycle 14 only, out_data={103,102,101,100}, rows_drained=1.
REQ-034 Backpressure: 8 back-to-back skewed rows with out_ready=0 -> array_stall=1 once count reaches 4, no overflow_err, and rows popped in order once out_ready=1.
REQ-035 Overflow: 9 rows with out_ready=0 -> overflow_err=1, 8 rows retained, the 9th lost, rows_drained=8.
REQ-036 Skew fault: col 2 valid one cycle late for a single row -> skew_err=1, no push, and subsequent correct rows drain normally; clear_err -> skew_err=0.
REQ-037 Weight phase: drain_enable=0 with col valids toggling -> no push and no errors.
REQ-038 Reset mid-drain: reset_n pulsed low with 3 rows buffered -> out_valid=0 and count=0 immediately, and no stale row appears after release.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array and its bottom-row drain logic.
package systolic_pkg;

  localparam int DEF_NUM_COL = 4;
  localparam int DEF_BW_ACCU = 32;

  typedef logic signed [DEF_BW_ACCU-1:0] accu_t;

  function automatic int row_bits(input int num_col, input int bw_accu);
    return num_col * bw_accu;
  endfunction

endpackage

// File: rtl/systolic_array_drain_if.sv
// Row-output valid/ready handshake carrying one deskewed array row.
interface systolic_array_drain_if
  import systolic_pkg::*;
#(
  parameter int NUM_COL = DEF_NUM_COL,
  parameter int BW_ACCU = DEF_BW_ACCU
);

  logic                                    out_valid;
  logic                                    out_ready;
  logic [row_bits(NUM_COL, BW_ACCU)-1:0]   out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);

endinterface

// File: rtl/drain_fifo.sv
// Synchronous row FIFO; the head row is presented combinationally and reads
// as zero while empty so the output is never undefined.
module drain_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [WIDTH-1:0]             data_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH):0]       count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en, rd_en;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // A push into a full FIFO is only accepted when a pop frees the slot.
  assign rd_en = pop_i & ~empty_o;
  assign wr_en = push_i & (~full_o | rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(rd_en);
    count_d  = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/systolic_array_drain.sv
// Deskews the skewed bottom-row outputs of a systolic array into whole rows,
// flags skew/overflow faults, and buffers rows toward a valid/ready consumer.
module systolic_array_drain
  import systolic_pkg::*;
#(
  parameter int NUM_COL    = DEF_NUM_COL,
  parameter int BW_ACCU    = DEF_BW_ACCU,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  drain_enable,
  input  logic [NUM_COL-1:0]                    col_valid_in,
  input  logic [row_bits(NUM_COL, BW_ACCU)-1:0] col_data_in,
  systolic_array_drain_if.master                out_if,
  output logic                                  array_stall,
  output logic                                  skew_err,
  output logic                                  overflow_err,
  input  logic                                  clear_err,
  output logic [15:0]                           rows_drained
);

  localparam int RW = row_bits(NUM_COL, BW_ACCU);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] STALL_LVL = CW'(FIFO_DEPTH - NUM_COL);

  logic [NUM_COL-1:0] aligned_vld;
  logic [RW-1:0]      aligned_row;

  // Column c lags column 0 by c cycles, so it is delayed NUM_COL-1-c cycles.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_COL; gi++) begin : g_col
      localparam int DEPTH = NUM_COL - 1 - gi;
      logic               vld_d;
      logic [BW_ACCU-1:0] dat_d;

      assign vld_d = col_valid_in[gi] & drain_enable;
      assign dat_d = col_data_in[gi*BW_ACCU +: BW_ACCU];

      if (DEPTH == 0) begin : g_pass
        assign aligned_vld[gi]                     = vld_d;
        assign aligned_row[gi*BW_ACCU +: BW_ACCU]  = dat_d;
      end else begin : g_dly
        logic               vld_q [DEPTH];
        logic [BW_ACCU-1:0] dat_q [DEPTH];

        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
              vld_q[i] <= 1'b0;
              dat_q[i] <= '0;
            end
          end else begin
            vld_q[0] <= vld_d;
            dat_q[0] <= dat_d;
            for (int i = 1; i < DEPTH; i++) begin
              vld_q[i] <= vld_q[i-1];
              dat_q[i] <= dat_q[i-1];
            end
          end
        end

        assign aligned_vld[gi]                    = vld_q[DEPTH-1];
        assign aligned_row[gi*BW_ACCU +: BW_ACCU] = dat_q[DEPTH-1];
      end
    end
  endgenerate

  logic          all_vld, any_vld, pop, push_ok, overflow_ev, skew_ev;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  assign all_vld     = &aligned_vld;
  assign any_vld     = |aligned_vld;
  assign pop         = out_if.out_valid & out_if.out_ready;
  assign push_ok     = all_vld & (~fifo_full | pop);
  assign overflow_ev = all_vld & fifo_full & ~pop;
  assign skew_ev     = any_vld & ~all_vld;

  drain_fifo #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push_ok),
    .pop_i   (pop),
    .data_i  (aligned_row),
    .data_o  (out_if.out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign out_if.out_valid = ~fifo_empty;
  assign array_stall      = (fifo_count >= STALL_LVL);

  logic        skew_q, skew_d;
  logic        ovf_q, ovf_d;
  logic [15:0] rows_q, rows_d;

  // A new error event on the same edge as clear_err keeps the flag set.
  always_comb begin
    skew_d = skew_ev | (skew_q & ~clear_err);
    ovf_d  = overflow_ev | (ovf_q & ~clear_err);
    rows_d = push_ok ? rows_q + 16'd1 : rows_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skew_q <= 1'b0;
      ovf_q  <= 1'b0;
      rows_q <= '0;
    end else begin
      skew_q <= skew_d;
      ovf_q  <= ovf_d;
      rows_q <= rows_d;
    end
  end

  assign skew_err     = skew_q;
  assign overflow_err = ovf_q;
  assign rows_drained = rows_q;

endmodule

// File: tb/tb_systolic_array_drain.sv
// Self-checking bench: scenario tasks plus a randomized run against a
// row-level reference model of the drain.
module tb_systolic_array_drain;
  import systolic_pkg::*;

  localparam int NC = 4;
  localparam int BW = 32;
  localparam int FD = 8;
  localparam int RW = NC * BW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          drain_enable = 1'b0;
  logic          clear_err = 1'b0;
  logic [NC-1:0] col_valid_in = '0;
  logic [RW-1:0] col_data_in = '0;
  logic          array_stall, skew_err, overflow_err;
  logic [15:0]   rows_drained;

  int errors = 0;
  int checks = 0;

  systolic_array_drain_if #(.NUM_COL(NC), .BW_ACCU(BW)) out_if ();

  systolic_array_drain #(.NUM_COL(NC), .BW_ACCU(BW), .FIFO_DEPTH(FD)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .drain_enable (drain_enable),
    .col_valid_in (col_valid_in),
    .col_data_in  (col_data_in),
    .out_if       (out_if),
    .array_stall  (array_stall),
    .skew_err     (skew_err),
    .overflow_err (overflow_err),
    .clear_err    (clear_err),
    .rows_drained (rows_drained)
  );

  always #5 clk = ~clk;

  // Reference model: input history, row queue, sticky flags, push counter.
  logic [NC-1:0] h_v [NC];
  logic [RW-1:0] h_d [NC];
  logic [RW-1:0] m_q [$];
  logic          m_skew, m_ovf;
  logic [15:0]   m_rows;

  // Stimulus plan: row r starts on local cycle pl_start[r]; pl_late[r] names
  // a column that arrives one cycle late (-1 for none).
  logic [RW-1:0] pl_row [$];
  int            pl_start [$];
  int            pl_late [$];

  task automatic model_reset();
    for (int k = 0; k < NC; k++) begin
      h_v[k] = '0;
      h_d[k] = '0;
    end
    m_q.delete();
    m_skew = 1'b0;
    m_ovf  = 1'b0;
    m_rows = '0;
  endtask

  task automatic model_edge();
    logic [NC-1:0] al_v;
    logic [RW-1:0] al_d;
    logic [RW-1:0] hd;
    logic          pop, full, skew_ev, ovf_ev;
    for (int k = NC - 1; k > 0; k--) begin
      h_v[k] = h_v[k-1];
      h_d[k] = h_d[k-1];
    end
    h_v[0] = drain_enable ? col_valid_in : '0;
    h_d[0] = col_data_in;
    for (int c = 0; c < NC; c++) begin
      al_v[c] = h_v[NC-1-c][c];
      hd = h_d[NC-1-c];
      al_d[c*BW +: BW] = hd[c*BW +: BW];
    end
    pop     = (m_q.size() > 0) && out_if.out_ready;
    full    = (m_q.size() >= FD);
    skew_ev = (|al_v) && !(&al_v);
    ovf_ev  = (&al_v) && full && !pop;
    if (pop) m_q.delete(0);
    if ((&al_v) && (!full || pop)) begin
      m_q.push_back(al_d);
      m_rows = m_rows + 16'd1;
    end
    m_skew = skew_ev | (m_skew & ~clear_err);
    m_ovf  = ovf_ev | (m_ovf & ~clear_err);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic plan_clear();
    pl_row.delete();
    pl_start.delete();
    pl_late.delete();
  endtask

  task automatic add_row(input logic [RW-1:0] row, input int start, input int late);
    pl_row.push_back(row);
    pl_start.push_back(start);
    pl_late.push_back(late);
  endtask

  task automatic drive_plan(input int k);
    logic [NC-1:0] v;
    logic [RW-1:0] d;
    logic [RW-1:0] rw;
    v = '0;
    d = '0;
    for (int r = 0; r < pl_row.size(); r++) begin
      rw = pl_row[r];
      for (int c = 0; c < NC; c++) begin
        if (pl_start[r] + c + ((c == pl_late[r]) ? 1 : 0) == k) begin
          v[c] = 1'b1;
          d[c*BW +: BW] = rw[c*BW +: BW];
        end
      end
    end
    col_valid_in = v;
    col_data_in  = d;
  endtask

  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] r;
    accu_t         a;
    for (int c = 0; c < NC; c++) begin
      a = accu_t'($urandom());
      r[c*BW +: BW] = a;
    end
    return r;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    col_valid_in = '0;
    col_data_in = '0;
    clear_err = 1'b0;
    drain_enable = 1'b0;
    out_if.out_ready = 1'b0;
    model_reset();
    plan_clear();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_if.out_valid); end
    checks++; if (out_if.out_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", out_if.out_data); end
    checks++; if (array_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", array_stall); end
    checks++; if ({skew_err, overflow_err} !== 2'b00) begin errors++; $display("FAIL reset_err got=%b%b exp=00", skew_err, overflow_err); end
    checks++; if (rows_drained !== 16'd0) begin errors++; $display("FAIL reset_rows got=%0d exp=0", rows_drained); end
    $display("test_reset done");
  endtask

  task automatic test_single_row();
    logic [RW-1:0] row;
    logic [RW-1:0] exp;
    do_reset();
    drain_enable = 1'b1;
    out_if.out_ready = 1'b1;
    for (int c = 0; c < NC; c++) row[c*BW +: BW] = 32'(100 + c);
    exp = {32'd103, 32'd102, 32'd101, 32'd100};
    add_row(row, 0, -1);
    for (int k = 0; k < 12; k++) begin
      drive_plan(k);
      tick();
      checks++;
      if (out_if.out_valid !== (k + 1 == NC)) begin
        errors++; $display("FAIL single_valid cycle=%0d got=%b exp=%b", k + 1, out_if.out_valid, (k + 1 == NC));
      end
      if (k + 1 == NC) begin
        checks++;
        if (out_if.out_data !== exp) begin errors++; $display("FAIL single_data got=%h exp=%h", out_if.out_data, exp); end
      end
    end
    checks++; if (rows_drained !== 16'd1) begin errors++; $display("FAIL single_rows got=%0d exp=1", rows_drained); end
    $display("test_single_row done");
  endtask

  task automatic test_fill(input int n_rows);
    logic [RW-1:0] sent [$];
    int            k;
    do_reset();
    drain_enable = 1'b1;
    for (int r = 0; r < n_rows; r++) begin
      sent.push_back(rand_row());
      add_row(sent[r], r, -1);
    end
    for (k = 0; k < n_rows + NC + 2; k++) begin
      drive_plan(k);
      tick();
      checks++;
      if (array_stall !== (m_q.size() >= FD - NC)) begin
        errors++; $display("FAIL fill_stall cycle=%0d got=%b exp=%b", k + 1, array_stall, (m_q.size() >= FD - NC));
      end
      if (n_rows <= FD) begin
        checks++;
        if (overflow_err !== 1'b0) begin errors++; $display("FAIL fill_no_ovf cycle=%0d got=%b exp=0", k + 1, overflow_err); end
      end
    end
    checks++; if (array_stall !== 1'b1) begin errors++; $display("FAIL fill_stall_full got=%b exp=1", array_stall); end
    checks++; if (overflow_err !== (n_rows > FD)) begin errors++; $display("FAIL fill_ovf got=%b exp=%b", overflow_err, (n_rows > FD)); end
    checks++; if (rows_drained !== 16'(FD)) begin errors++; $display("FAIL fill_rows got=%0d exp=%0d", rows_drained, FD); end
    out_if.out_ready = 1'b1;
    for (int i = 0; i < FD; i++) begin
      checks++;
      if (out_if.out_valid !== 1'b1 || out_if.out_data !== sent[i]) begin
        errors++; $display("FAIL fill_order row=%0d got=%b/%h exp=1/%h", i, out_if.out_valid, out_if.out_data, sent[i]);
      end
      drive_plan(k);
      k++;
      tick();
    end
    checks++; if (out_if.out_valid !== 1'b0) begin errors++; $display("FAIL fill_empty got=%b exp=0", out_if.out_valid); end
    $display("test_fill rows=%0d done", n_rows);
  endtask

  task automatic test_skew();
    logic [RW-1:0] good [2];
    int            idx = 0;
    do_reset();
    drain_enable = 1'b1;
    out_if.out_ready = 1'b1;
    good[0] = rand_row();
    good[1] = rand_row();
    add_row(rand_row(), 0, 2);
    add_row(good[0], 8, -1);
    add_row(good[1], 9, -1);
    for (int k = 0; k < 20; k++) begin
      drive_plan(k);
      tick();
      if (k + 1 == NC) begin
        checks++;
        if (skew_err !== 1'b1) begin errors++; $display("FAIL skew_set got=%b exp=1", skew_err); end
      end
      if (k == 7) begin
        checks++;
        if (rows_drained !== 16'd0 || out_if.out_valid !== 1'b0) begin
          errors++; $display("FAIL skew_no_push rows=%0d valid=%b exp=0/0", rows_drained, out_if.out_valid);
        end
      end
      if (out_if.out_valid === 1'b1) begin
        checks++;
        if (idx > 1 || out_if.out_data !== good[idx > 1 ? 1 : idx]) begin
          errors++; $display("FAIL skew_row idx=%0d got=%h", idx, out_if.out_data);
        end
        idx++;
      end
    end
    checks++; if (idx !== 2 || rows_drained !== 16'd2) begin errors++; $display("FAIL skew_after rows_out=%0d cnt=%0d exp=2/2", idx, rows_drained); end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    checks++; if (skew_err !== 1'b0) begin errors++; $display("FAIL skew_clear got=%b exp=0", skew_err); end
    $display("test_skew done");
  endtask

  task automatic test_weight_phase();
    do_reset();
    out_if.out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      col_valid_in = NC'($urandom());
      col_data_in  = rand_row();
      tick();
      checks++;
      if ({out_if.out_valid, skew_err, overflow_err} !== 3'b000) begin
        errors++; $display("FAIL weight cycle=%0d valid/skew/ovf got=%b%b%b exp=000", k, out_if.out_valid, skew_err, overflow_err);
      end
    end
    col_valid_in = '0;
    drain_enable = 1'b1;
    repeat (NC) tick();
    checks++; if (rows_drained !== 16'd0 || skew_err !== 1'b0) begin errors++; $display("FAIL weight_end rows=%0d skew=%b exp=0/0", rows_drained, skew_err); end
    $display("test_weight_phase done");
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    drain_enable = 1'b1;
    for (int r = 0; r < 4; r++) add_row(rand_row(), r, -1);
    for (int k = 0; k < NC + 2; k++) begin
      drive_plan(k);
      tick();
    end
    checks++; if (out_if.out_valid !== 1'b1 || rows_drained !== 16'd3) begin errors++; $display("FAIL mid_pre valid=%b rows=%0d exp=1/3", out_if.out_valid, rows_drained); end
    reset_n = 1'b0;
    #1;
    checks++; if (out_if.out_valid !== 1'b0 || out_if.out_data !== '0) begin errors++; $display("FAIL mid_async valid=%b data=%h exp=0/0", out_if.out_valid, out_if.out_data); end
    checks++; if (array_stall !== 1'b0 || rows_drained !== 16'd0) begin errors++; $display("FAIL mid_async stall=%b rows=%0d exp=0/0", array_stall, rows_drained); end
    model_reset();
    plan_clear();
    col_valid_in = '0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    out_if.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (out_if.out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale cycle=%0d got=%b exp=0", k, out_if.out_valid); end
    end
    $display("test_reset_mid_drain done");
  endtask

  task automatic test_random();
    int t = 0;
    do_reset();
    for (int r = 0; r < 60; r++) begin
      add_row(rand_row(), t, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, NC - 1)) : -1);
      t += int'($urandom_range(1, 4));
    end
    for (int k = 0; k < t + NC + 40; k++) begin
      drive_plan(k);
      drain_enable = ($urandom_range(0, 19) != 0);
      out_if.out_ready = ((k / 40) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clear_err = ($urandom_range(0, 15) == 0);
      tick();
      checks++;
      if (out_if.out_valid !== (m_q.size() > 0)) begin errors++; $display("FAIL rnd_valid cycle=%0d got=%b exp=%b", k, out_if.out_valid, (m_q.size() > 0)); end
      if (m_q.size() > 0) begin
        checks++;
        if (out_if.out_data !== m_q[0]) begin errors++; $display("FAIL rnd_data cycle=%0d got=%h exp=%h", k, out_if.out_data, m_q[0]); end
      end
      checks++;
      if (array_stall !== (m_q.size() >= FD - NC)) begin errors++; $display("FAIL rnd_stall cycle=%0d got=%b exp=%b", k, array_stall, (m_q.size() >= FD - NC)); end
      checks++;
      if (skew_err !== m_skew || overflow_err !== m_ovf) begin errors++; $display("FAIL rnd_err cycle=%0d got=%b%b exp=%b%b", k, skew_err, overflow_err, m_skew, m_ovf); end
      checks++;
      if (rows_drained !== m_rows) begin errors++; $display("FAIL rnd_rows cycle=%0d got=%0d exp=%0d", k, rows_drained, m_rows); end
    end
    clear_err = 1'b0;
    $display("test_random done rows=%0d", m_rows);
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_fill(FD);
    test_fill(FD + 1);
    test_skew();
    test_weight_phase();
    test_reset_mid_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
